// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter sharing one combinational ALU on a fixed 3-cycle schedule
module alu_share_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [4:0]  shamt0,
  input  logic [4:0]  shamt1,
  output logic [3:0]  ALUOperation,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [4:0]  Shamt,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        zero,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic RR = (RR_EN != 0);

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        pick1;
  logic        op_legal;

  // Winner selection: requester 1 wins when alone, or on a tie when
  // round-robin is on and requester 0 held the ALU last.
  always_comb begin
    pick1 = req1 & (~req0 | (RR & ~last_grant_q));
  end

  // Opcodes the shared ALU implements; anything else is flagged but still run.
  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state: latch winner operands on grant, capture ALU output at end of EXEC.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    shamt_d      = shamt_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d      = EXEC;
          win_d        = pick1;
          last_grant_d = pick1;
          op_d         = pick1 ? op1    : op0;
          a_d          = pick1 ? a1     : a0;
          b_d          = pick1 ? b1     : b0;
          shamt_d      = pick1 ? shamt1 : shamt0;
        end
      end
      EXEC: begin
        state_d  = RESP;
        result_d = ALUResult;
        zero_d   = Zero;
        err_d    = ~op_legal;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      shamt_q      <= 5'd0;
      result_q     <= 32'd0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shamt_q      <= shamt_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign grant0       = busy & ~win_q;
  assign grant1       = busy & win_q;
  assign done0        = (state_q == RESP) & ~win_q;
  assign done1        = (state_q == RESP) & win_q;
  assign ALUOperation = op_q;
  assign A            = a_q;
  assign B            = b_q;
  assign Shamt        = shamt_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign err          = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (round-robin and fixed-priority instances)
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic [4:0]  shamt0, shamt1;

  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_sh;
  logic        alu_zero;
  logic        grant0, grant1, done0, done1, zero, err, busy;
  logic [31:0] result;

  logic [3:0]  fp_op;
  logic [31:0] fp_a, fp_b, fp_res;
  logic [4:0]  fp_sh;
  logic        fp_zero_in;
  logic        fp_grant0, fp_grant1, fp_done0, fp_done1, fp_zero, fp_err, fp_busy;
  logic [31:0] fp_result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          who;
    logic [31:0] res;
    logic        z;
    logic        e;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a ^ b;
      4'b0011: alu_f = a + b;
      4'b0100: alu_f = a - b;
      4'b1000: alu_f = b << sh;
      4'b1001: alu_f = b >> sh;
      4'b1010: alu_f = $unsigned($signed(b) >>> sh);
      4'b1011: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_f = ~(a | b);
      4'b1110: alu_f = {b[15:0], 16'h0000};
      default: alu_f = a + b;
    endcase
  endfunction

  function automatic logic illegal_f(input logic [3:0] op);
    illegal_f = !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110});
  endfunction

  assign alu_res    = alu_f(alu_op, alu_a, alu_b, alu_sh);
  assign alu_zero   = (alu_res == 32'd0);
  assign fp_res     = alu_f(fp_op, fp_a, fp_b, fp_sh);
  assign fp_zero_in = (fp_res == 32'd0);

  alu_share_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .shamt0(shamt0), .shamt1(shamt1),
    .ALUOperation(alu_op), .A(alu_a), .B(alu_b), .Shamt(alu_sh),
    .ALUResult(alu_res), .Zero(alu_zero),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .err(err), .busy(busy)
  );

  alu_share_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .shamt0(shamt0), .shamt1(shamt1),
    .ALUOperation(fp_op), .A(fp_a), .B(fp_b), .Shamt(fp_sh),
    .ALUResult(fp_res), .Zero(fp_zero_in),
    .grant0(fp_grant0), .grant1(fp_grant1), .done0(fp_done0), .done1(fp_done1),
    .result(fp_result), .zero(fp_zero), .err(fp_err), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e.who = who;
    e.res = alu_f(op, a, b, sh);
    e.z   = (e.res == 32'd0);
    e.e   = illegal_f(op);
    sb.push_back(e);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 4'd0; op1 = 4'd0; a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
    shamt0 = 5'd0; shamt1 = 5'd0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Advance until a done pulse, then pop and compare the scoreboard head.
  task automatic wait_done(input int budget);
    exp_t e;
    int   who_act;
    for (int c = 0; c < budget; c++) begin
      tick;
      if (done0 || done1) begin
        checks++;
        if (done0 && done1) begin
          failures++;
          $display("FAIL done_both got=%b%b exp=one-hot", done0, done1);
        end
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_empty got=done exp=no_done");
          return;
        end
        e = sb.pop_front();
        who_act = done1 ? 1 : 0;
        checks++;
        if (who_act !== e.who) begin
          failures++;
          $display("FAIL sb_who got=%0d exp=%0d", who_act, e.who);
        end
        if (result !== e.res) begin
          failures++;
          $display("FAIL sb_result got=%0h exp=%0h", result, e.res);
        end
        if (zero !== e.z || err !== e.e) begin
          failures++;
          $display("FAIL sb_flags got=z%b e%b exp=z%b e%b", zero, err, e.z, e.e);
        end
        return;
      end
    end
    checks++; failures++;
    $display("FAIL done_timeout got=no_done exp=done_within_%0d", budget);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 4'd0; op1 = 4'd0; a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
    shamt0 = 5'd0; shamt1 = 5'd0;
    tick;
    tick;
    checks++;
    if ({grant0, grant1, done0, done1, busy, zero, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {grant0, grant1, done0, done1, busy, zero, err});
    end
    checks++;
    if (result !== 32'd0 || alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sh !== 5'd0) begin
      failures++;
      $display("FAIL reset_data got=res%0h op%0h a%0h b%0h sh%0h exp=all_zero", result, alu_op, alu_a, alu_b, alu_sh);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    req0 = 1'b1; op0 = 4'b0011; a0 = 32'd5; b0 = 32'd7; shamt0 = 5'd0;
    push_exp(0, 4'b0011, 32'd5, 32'd7, 5'd0);
    tick;
    checks++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got=g0%b g1%b busy%b exp=g0 1 g1 0 busy 1", grant0, grant1, busy);
    end
    checks++;
    if (alu_op !== 4'b0011 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++;
      $display("FAIL single_drive got=op%0h a%0d b%0d exp=op3 a5 b7", alu_op, alu_a, alu_b);
    end
    wait_done(1);
    req0 = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || grant0 !== 1'b0 || result !== 32'd12) begin
      failures++;
      $display("FAIL single_idle got=busy%b g0%b res%0d exp=busy0 g0 0 res12", busy, grant0, result);
    end
  endtask

  task automatic test_zero_illegal;
    req1 = 1'b1; op1 = 4'b0100; a1 = 32'd9; b1 = 32'd9; shamt1 = 5'd0;
    push_exp(1, 4'b0100, 32'd9, 32'd9, 5'd0);
    tick;
    op1 = 4'b0111; a1 = 32'd3; b1 = 32'd4;
    checks++;
    if (grant1 !== 1'b1 || alu_op !== 4'b0100 || alu_a !== 32'd9) begin
      failures++;
      $display("FAIL zero_hold got=g1%b op%0h a%0d exp=g1 1 op4 a9", grant1, alu_op, alu_a);
    end
    push_exp(1, 4'b0111, 32'd3, 32'd4, 5'd0);
    wait_done(1);
    tick;
    checks++;
    if (busy !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL rearb_idle got=busy%b zero%b exp=busy0 zero1", busy, zero);
    end
    tick;
    checks++;
    if (grant1 !== 1'b1 || alu_op !== 4'b0111) begin
      failures++;
      $display("FAIL rearb_grant got=g1%b op%0h exp=g1 1 op7", grant1, alu_op);
    end
    wait_done(1);
    req1 = 1'b0;
    tick;
  endtask

  task automatic test_op_table;
    logic [3:0]  ops[8];
    logic [31:0] av, bv;
    logic [4:0]  sv;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b1000; ops[3] = 4'b1010;
    ops[4] = 4'b1011; ops[5] = 4'b1100; ops[6] = 4'b1110; ops[7] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      av = $urandom; bv = $urandom | 32'h8000_0000; sv = 5'($urandom_range(1, 31));
      req0 = 1'b1; op0 = ops[i]; a0 = av; b0 = bv; shamt0 = sv;
      push_exp(0, ops[i], av, bv, sv);
      tick;
      checks++;
      if (alu_sh !== sv || alu_b !== bv) begin
        failures++;
        $display("FAIL table_drive got=sh%0d b%0h exp=sh%0d b%0h", alu_sh, alu_b, sv, bv);
      end
      wait_done(2);
      req0 = 1'b0;
      tick;
    end
  endtask

  task automatic test_contention;
    exp_t e;
    int   dones = 0, fp_dones = 0, last_c = 0, who_act;
    apply_reset();
    req0 = 1'b1; op0 = 4'b0011; a0 = 32'd1;  b0 = 32'd2;
    req1 = 1'b1; op1 = 4'b0100; a1 = 32'd10; b1 = 32'd3;
    for (int k = 0; k < 2; k++) begin
      push_exp(0, 4'b0011, 32'd1, 32'd2, 5'd0);
      push_exp(1, 4'b0100, 32'd10, 32'd3, 5'd0);
    end
    for (int c = 0; c < 20 && dones < 4; c++) begin
      tick;
      if (grant0 && grant1) begin
        checks++; failures++;
        $display("FAIL rr_both_grant got=11 exp=one-hot");
      end
      if (fp_grant1 || fp_done1) begin
        checks++; failures++;
        $display("FAIL fp_grant1 got=g1%b d1%b exp=00", fp_grant1, fp_done1);
      end
      if (fp_done0) begin
        fp_dones++;
        checks++;
        if (fp_result !== 32'd3) begin
          failures++;
          $display("FAIL fp_result got=%0d exp=3", fp_result);
        end
      end
      if (done0 || done1) begin
        e = sb.pop_front();
        who_act = done1 ? 1 : 0;
        checks++;
        if (who_act !== e.who || result !== e.res || zero !== e.z || err !== e.e) begin
          failures++;
          $display("FAIL rr_order got=who%0d res%0d exp=who%0d res%0d", who_act, result, e.who, e.res);
        end
        if (dones > 0) begin
          checks++;
          if (c - last_c !== 3) begin
            failures++;
            $display("FAIL rr_spacing got=%0d exp=3", c - last_c);
          end
        end
        last_c = c;
        dones++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (dones !== 4) begin
      failures++;
      $display("FAIL rr_timeout got=%0d exp=4", dones);
    end
    checks++;
    if (fp_dones !== 4) begin
      failures++;
      $display("FAIL fp_count got=%0d exp=4", fp_dones);
    end
    sb.delete();
    tick;
    tick;
  endtask

  task automatic test_reset_mid_op;
    req0 = 1'b1; op0 = 4'b0011; a0 = 32'd20; b0 = 32'd22; shamt0 = 5'd3;
    tick;
    checks++;
    if (grant0 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got=%b exp=1", grant0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({grant0, grant1, done0, done1, busy, zero, err} !== 7'b0 ||
        alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sh !== 5'd0 || result !== 32'd0) begin
      failures++;
      $display("FAIL midrst_now got=ctl%b op%0h a%0h exp=all_zero",
               {grant0, grant1, done0, done1, busy, zero, err}, alu_op, alu_a);
    end
    tick;
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold got=d0%b busy%b exp=00", done0, busy);
    end
    reset = 1'b0;
    push_exp(0, 4'b0011, 32'd20, 32'd22, 5'd3);
    tick;
    checks++;
    if (grant0 !== 1'b1 || alu_a !== 32'd20) begin
      failures++;
      $display("FAIL midrst_regrant got=g0%b a%0d exp=g0 1 a20", grant0, alu_a);
    end
    wait_done(1);
    req0 = 1'b0;
    tick;
  endtask

  task automatic test_operand_hold;
    req0 = 1'b1; op0 = 4'b0011; a0 = 32'd1; b0 = 32'd1; shamt0 = 5'd0;
    push_exp(0, 4'b0011, 32'd1, 32'd1, 5'd0);
    tick;
    a0 = 32'd100;
    wait_done(1);
    req0 = 1'b0;
    checks++;
    if (alu_a !== 32'd1) begin
      failures++;
      $display("FAIL hold_drive got=%0d exp=1", alu_a);
    end
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_illegal();
    test_op_table();
    test_contention();
    test_reset_mid_op();
    test_operand_hold();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
